frac_logic_cfg_loader: RTL

Serial configuration loader sitting directly upstream of the frac_logic tile. It accepts a framed bit stream on the programming clock, assembles it in a shadow register, checks an even-parity trailer, and atomically commits the result onto the true/complement configuration buses. Those buses drive the tile's feedthrough_mem_in / feedthrough_mem_inb: 33 bits for frac_lut5_arith plus 1 output-mux select. The block also regenerates ccff_tail so tiles can be daisy-chained.

---
 rtl/frac_logic_cfg_pkg.sv | 17 +
 rtl/frac_logic_cfg_shadow.sv | 60 ++++++
 rtl/frac_logic_cfg_loader.sv | 139 +++++++++++++
 3 files changed

// File: rtl/frac_logic_cfg_pkg.sv
// Shared types and constants for the frac_logic configuration loader.
// Field indices describe the layout of one configuration frame.
package frac_logic_cfg_pkg;

  localparam int FRAC_LOGIC_CFG_BITS = 34;
  localparam int LUT_LSB             = 0;
  localparam int LUT_MSB             = 32;
  localparam int OUTMUX_SEL          = 33;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

endpackage

// File: rtl/frac_logic_cfg_shadow.sv
// Shadow shift register for one configuration frame, plus the daisy-chain
// tail flop and the running even-parity accumulator over the data bits.
module frac_logic_cfg_shadow
  import frac_logic_cfg_pkg::*;
#(
  parameter int NUM_BITS = FRAC_LOGIC_CFG_BITS
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                shift_i,
  input  logic                bit_i,
  output logic [NUM_BITS-1:0] shadow_o,
  output logic                tail_o,
  output logic                parity_o
);

  logic [NUM_BITS-1:0] shadow_q, shadow_d;
  logic                tail_q, tail_d;
  logic                parity_q, parity_d;

  // New bits enter at the top so the first bit of a frame ends up in bit 0.
  generate
    for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_shift
      if (gi == NUM_BITS - 1) begin : g_top
        assign shadow_d[gi] = shift_i ? bit_i : shadow_q[gi];
      end else begin : g_mid
        assign shadow_d[gi] = shift_i ? shadow_q[gi+1] : shadow_q[gi];
      end
    end
  endgenerate

  always_comb begin
    tail_d   = tail_q;
    parity_d = parity_q;
    if (clear_i) begin
      parity_d = 1'b0;
    end else if (shift_i) begin
      tail_d   = shadow_q[0];
      parity_d = parity_q ^ bit_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      tail_q   <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      tail_q   <= tail_d;
      parity_q <= parity_d;
    end
  end

  assign shadow_o = shadow_q;
  assign tail_o   = tail_q;
  assign parity_o = parity_q;

endmodule

// File: rtl/frac_logic_cfg_loader.sv
// Serial configuration loader for a frac_logic tile: framed shift-in, parity
// check and atomic commit onto true/complement configuration buses.
module frac_logic_cfg_loader
  import frac_logic_cfg_pkg::*;
#(
  parameter int NUM_BITS  = FRAC_LOGIC_CFG_BITS,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic                cfg_start,
  input  logic                ccff_head,
  input  logic                ccff_valid,
  output logic                ccff_ready,
  output logic                ccff_tail,
  output logic [NUM_BITS-1:0] mem_out,
  output logic [NUM_BITS-1:0] mem_outb,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int              CNT_W    = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 1);

  cfg_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BITS-1:0] mem_q, mem_d;
  logic [NUM_BITS-1:0] memb_q, memb_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                pend_q, pend_d;

  logic                sh_clear, sh_shift, sh_parity;
  logic [NUM_BITS-1:0] sh_shadow;
  logic                accept;

  assign ccff_ready = (state_q == SHIFT) || (state_q == PARITY);
  assign accept     = ccff_valid & ccff_ready;

  frac_logic_cfg_shadow #(
    .NUM_BITS(NUM_BITS)
  ) u_shadow (
    .clk_i   (prog_clk),
    .rst_ni  (prog_reset_n),
    .clear_i (sh_clear),
    .shift_i (sh_shift),
    .bit_i   (ccff_head),
    .shadow_o(sh_shadow),
    .tail_o  (ccff_tail),
    .parity_o(sh_parity)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    memb_d   = memb_q;
    done_d   = 1'b0;
    err_d    = err_q;
    pend_d   = 1'b0;
    sh_clear = 1'b0;
    sh_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A start seen during COMMIT is replayed here one cycle late.
        if (cfg_start || pend_q) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          sh_clear = 1'b1;
          err_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (cfg_start) begin
          cnt_d    = '0;
          sh_clear = 1'b1;
          err_d    = 1'b0;
        end else if (accept) begin
          sh_shift = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = PARITY_EN ? PARITY : COMMIT;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (cfg_start) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          sh_clear = 1'b1;
          err_d    = 1'b0;
        end else if (accept) begin
          if ((sh_parity ^ ccff_head) == 1'b0) begin
            state_d = COMMIT;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      COMMIT: begin
        mem_d   = sh_shadow;
        memb_d  = ~sh_shadow;
        done_d  = 1'b1;
        pend_d  = cfg_start;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mem_q   <= '0;
      memb_q  <= '1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mem_q   <= mem_d;
      memb_q  <= memb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

  assign mem_out  = mem_q;
  assign mem_outb = memb_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;

endmodule
